pc_gen: RTL and testbench



---
 rtl/pc_gen_if.sv | 35 +++
 rtl/pc_gen.sv | 112 +++++++++++
 tb/tb_pc_gen.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Fetch-PC request bundle between the PC generator (master) and fetch/backend (slave).
interface pc_gen_if #(
    parameter int XLEN    = 32,
    parameter int FETCH_N = 2,
    parameter int EPOCH_W = 2
);
    logic               pc_ready;
    logic               exc_valid;
    logic [XLEN-1:0]    exc_target;
    logic               br_valid;
    logic [XLEN-1:0]    br_target;
    logic               pred_valid;
    logic [XLEN-1:0]    pred_target;
    logic               halt_req;
    logic [XLEN-1:0]    pc;
    logic               pc_valid;
    logic [FETCH_N-1:0] pc_mask;
    logic [EPOCH_W-1:0] epoch;
    // Debug view of the generator FSM: 0 = BOOT, 1 = RUN, 2 = HALT.
    logic [1:0]         dbg_state;

    // Handshake: a request transfers on a cycle where pc_valid and pc_ready are both high;
    // redirects are sampled every cycle independently of that handshake.
    modport master (
        input  pc_ready, exc_valid, exc_target, br_valid, br_target,
               pred_valid, pred_target, halt_req,
        output pc, pc_valid, pc_mask, epoch, dbg_state
    );

    modport slave (
        output pc_ready, exc_valid, exc_target, br_valid, br_target,
               pred_valid, pred_target, halt_req,
        input  pc, pc_valid, pc_mask, epoch, dbg_state
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch-PC generator: advances one fetch block per accepted request, applies prioritised
// redirects (exception > branch > prediction), tracks a redirect epoch and a HALT state.
module pc_gen #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] BEGIN_ADDR = 32'h1C00_0000,
    parameter int              INST_BYTES = 4,
    parameter int              FETCH_N    = 2,
    parameter int              EPOCH_W    = 2
) (
    input  logic      clk,
    input  logic      rst,
    pc_gen_if.master  bus
);
    localparam int              BLK        = FETCH_N * INST_BYTES;
    localparam int              OFF_W      = $clog2(INST_BYTES);
    localparam int              BLK_W      = $clog2(BLK);
    localparam logic [XLEN-1:0] INST_ALIGN = ~(XLEN'(INST_BYTES) - XLEN'(1));
    localparam logic [XLEN-1:0] BLK_ALIGN  = ~(XLEN'(BLK) - XLEN'(1));

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t             r_state;
    logic [XLEN-1:0]    r_pc;
    logic [EPOCH_W-1:0] r_epoch;

    logic               w_pc_valid;
    logic               w_fire;
    logic               w_halt_run;
    logic               w_redirect;
    logic               w_epoch_bump;
    logic [XLEN-1:0]    w_redir_target;
    logic [XLEN-1:0]    w_next_seq;
    logic [FETCH_N-1:0] w_mask;

    assign w_pc_valid   = (r_state == ST_RUN);
    assign w_fire       = w_pc_valid & bus.pc_ready;
    assign w_halt_run   = (r_state == ST_RUN) & bus.halt_req;
    assign w_redirect   = bus.exc_valid | bus.br_valid | bus.pred_valid;
    assign w_epoch_bump = bus.exc_valid | bus.br_valid;
    assign w_next_seq   = (r_pc & BLK_ALIGN) + XLEN'(BLK);

    always_comb begin
        w_redir_target = bus.pred_target;
        if (bus.exc_valid) begin
            w_redir_target = bus.exc_target;
        end else if (bus.br_valid) begin
            w_redir_target = bus.br_target;
        end
        w_redir_target = w_redir_target & INST_ALIGN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BOOT;
            r_pc    <= BEGIN_ADDR;
            r_epoch <= '0;
        end else begin
            case (r_state)
                ST_BOOT, ST_RUN: begin
                    // A redirect drops any unaccepted request and wins over sequential advance.
                    if (w_redirect) begin
                        r_pc <= w_redir_target;
                    end else if (w_fire || w_halt_run) begin
                        r_pc <= w_next_seq;
                    end
                    if (w_epoch_bump) begin
                        r_epoch <= r_epoch + EPOCH_W'(1);
                    end
                    if (r_state == ST_BOOT) begin
                        r_state <= ST_RUN;
                    end else if (bus.halt_req) begin
                        r_state <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (bus.exc_valid) begin
                        r_pc    <= bus.exc_target & INST_ALIGN;
                        r_epoch <= r_epoch + EPOCH_W'(1);
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_BOOT;
            endcase
        end
    end

    generate
        if (FETCH_N == 1) begin : g_single
            assign w_mask = w_pc_valid;
        end else begin : g_multi
            localparam int SLOT_W = BLK_W - OFF_W;
            logic [SLOT_W-1:0] w_slot;
            assign w_slot = r_pc[BLK_W-1:OFF_W];
            always_comb begin
                w_mask = '0;
                for (int i = 0; i < FETCH_N; i++) begin
                    w_mask[i] = w_pc_valid && (SLOT_W'(i) >= w_slot);
                end
            end
        end
    endgenerate

    assign bus.pc        = r_pc;
    assign bus.pc_valid  = w_pc_valid;
    assign bus.pc_mask   = w_mask;
    assign bus.epoch     = r_epoch;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_pc_gen.sv
// Randomised and directed bench for pc_gen with a queue-based scoreboard and a
// behavioural model written from the block/epoch/halt rules.
module tb_pc_gen;
    localparam int              XLEN       = 32;
    localparam logic [XLEN-1:0] BEGIN_ADDR = 32'h1C00_0000;
    localparam int              INST_BYTES = 4;
    localparam int              FETCH_N    = 2;
    localparam int              EPOCH_W    = 2;
    localparam int              BLK        = FETCH_N * INST_BYTES;
    localparam int              W          = XLEN + 1 + FETCH_N + EPOCH_W;

    logic clk;
    logic rst;

    pc_gen_if #(.XLEN(XLEN), .FETCH_N(FETCH_N), .EPOCH_W(EPOCH_W)) bus ();

    pc_gen #(
        .XLEN(XLEN), .BEGIN_ADDR(BEGIN_ADDR), .INST_BYTES(INST_BYTES),
        .FETCH_N(FETCH_N), .EPOCH_W(EPOCH_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int passed = 0;
    bit stim_done = 0;

    // ---------------- reference model ----------------
    // mode: 0 = booting, 1 = running, 2 = halted
    int                  m_mode;
    logic [XLEN-1:0]     m_pc;
    int                  m_epoch;

    function automatic logic [FETCH_N-1:0] model_mask(input logic [XLEN-1:0] pc, input bit valid);
        logic [FETCH_N-1:0] m;
        int slot;
        m = '0;
        slot = int'((pc % BLK) / INST_BYTES);
        for (int i = 0; i < FETCH_N; i++) m[i] = valid && (i >= slot);
        return m;
    endfunction

    function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] t);
        return t - (t % INST_BYTES);
    endfunction

    function automatic logic [W-1:0] model_out();
        bit v;
        v = (m_mode == 1);
        return {m_pc, v, model_mask(m_pc, v), EPOCH_W'(m_epoch % (1 << EPOCH_W))};
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit r, input bit rdy,
                        input bit exc, input logic [XLEN-1:0] exc_t,
                        input bit br,  input logic [XLEN-1:0] br_t,
                        input bit pred, input logic [XLEN-1:0] pred_t,
                        input bit halt);
        bit v;
        @(negedge clk);
        rst = r;
        bus.pc_ready = rdy;
        bus.exc_valid = exc;   bus.exc_target = exc_t;
        bus.br_valid = br;     bus.br_target = br_t;
        bus.pred_valid = pred; bus.pred_target = pred_t;
        bus.halt_req = halt;
        v = (m_mode == 1);
        if (r) begin
            m_mode = 0; m_pc = BEGIN_ADDR; m_epoch = 0;
        end else if (m_mode == 2) begin
            if (exc) begin
                m_pc = align(exc_t); m_epoch++; m_mode = 1;
            end
        end else begin
            if (exc)       m_pc = align(exc_t);
            else if (br)   m_pc = align(br_t);
            else if (pred) m_pc = align(pred_t);
            else if ((v && rdy) || (v && halt)) m_pc = (m_pc / BLK) * BLK + BLK;
            if (exc || br) m_epoch++;
            if (m_mode == 0)  m_mode = 1;
            else if (halt)    m_mode = 2;
        end
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input bit rdy);
        step(0, rdy, 0, '0, 0, '0, 0, '0, 0);
    endtask

    task automatic do_br(input logic [XLEN-1:0] t, input bit rdy);
        step(0, rdy, 0, '0, 1, t, 0, '0, 0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                act_v = {bus.pc, bus.pc_valid, bus.pc_mask, bus.epoch};
                checks++;
                if (act_v === exp_v) passed++;
                else $display("FAIL out_check t=%0t got pc=%h v=%b mask=%b ep=%0d expected pc=%h v=%b mask=%b ep=%0d",
                              $time, act_v[W-1 -: XLEN], act_v[FETCH_N+EPOCH_W], act_v[EPOCH_W +: FETCH_N],
                              act_v[EPOCH_W-1:0], exp_v[W-1 -: XLEN], exp_v[FETCH_N+EPOCH_W],
                              exp_v[EPOCH_W +: FETCH_N], exp_v[EPOCH_W-1:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        bus.pc_ready = 0; bus.exc_valid = 0; bus.exc_target = '0;
        bus.br_valid = 0; bus.br_target = '0; bus.pred_valid = 0;
        bus.pred_target = '0; bus.halt_req = 0;
        m_mode = 0; m_pc = BEGIN_ADDR; m_epoch = 0;

        // Reset, then sequential fetch with pc_ready held.
        step(1, 1, 0, '0, 0, '0, 0, '0, 0);
        step(1, 1, 0, '0, 0, '0, 0, '0, 0);
        repeat (4) idle(1);

        // Branch to a mid-block target while fetch stalls, then fire.
        do_br(32'h1C00_0106, 0);
        idle(0);
        idle(1);
        idle(1);

        // Priority: all three redirects together, then prediction alone.
        step(0, 1, 1, 32'h1C00_8000, 1, 32'h1C00_0200, 1, 32'h1C00_0300, 0);
        step(0, 1, 0, '0, 0, '0, 1, 32'h1C00_0300, 0);
        idle(1);

        // Five-cycle stall at 1C00_0010.
        do_br(32'h1C00_0010, 0);
        repeat (5) idle(0);

        // HALT entry, ignored branch, exception wake-up.
        do_br(32'h1C00_0020, 0);
        step(0, 0, 0, '0, 0, '0, 0, '0, 1);
        do_br(32'h1C00_0400, 1);
        step(0, 1, 0, '0, 0, '0, 1, 32'h1C00_0500, 1);
        step(0, 1, 1, 32'h1C00_1000, 0, '0, 0, '0, 0);
        idle(1);

        // Wrap-around at the top of the address space.
        do_br(32'hFFFF_FFF8, 0);
        idle(1);
        idle(1);

        // Reset while halted, then reset during a stall.
        step(0, 1, 0, '0, 0, '0, 0, '0, 1);
        idle(1);
        step(1, 1, 0, '0, 0, '0, 0, '0, 0);
        repeat (3) idle(1);
        do_br(32'h1C00_0044, 0);
        repeat (2) idle(0);
        step(1, 0, 0, '0, 0, '0, 0, '0, 0);
        repeat (3) idle(1);

        // Randomised traffic; halt only requested while running.
        for (int n = 0; n < 400; n++) begin
            bit r, rdy, e, b, p, h;
            r   = ($urandom_range(0, 99) < 2);
            rdy = ($urandom_range(0, 99) < 70);
            e   = ($urandom_range(0, 99) < 6);
            b   = ($urandom_range(0, 99) < 10);
            p   = ($urandom_range(0, 99) < 10);
            h   = (m_mode == 1) && ($urandom_range(0, 99) < 5);
            step(r, rdy, e, $urandom, b, $urandom, p, $urandom, h);
        end

        idle(0);
        @(negedge clk);
        @(negedge clk);
        stim_done = 1;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Safety bound so the run always terminates.
    initial begin
        #200000;
        if (!stim_done) begin
            $display("FAIL timeout got no completion expected finish before bound");
            $fatal(1, "timeout");
        end
    end
endmodule
